// File: rtl/exec_sequencer.sv
// Fetch/execute sequencer owning the 256x8 program/data memory, loaded byte-wise while idle/halted.
// 2 cycles per instruction (3 with a memory operand); load/start inputs are dropped while busy.
module exec_sequencer #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  output logic          busy,
  output logic          halted,
  output logic          err,
  output logic [7:0]    a_q,
  output logic [7:0]    b_q,
  output logic [7:0]    result,
  output logic          carry,
  output logic          result_valid,
  output logic [AW-1:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEMOP,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_MOVA  = 4'h1;
  localparam logic [3:0] OP_MOVB  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h8;
  localparam logic [3:0] OP_MOVAM = 4'h9;
  localparam logic [3:0] OP_MOVBM = 4'hA;
  localparam logic [3:0] OP_MOVM  = 4'hC;

  logic [7:0]    mem [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] ld_ptr_q, ld_ptr_d;
  logic [AW-1:0] ea_q, ea_d;
  logic [3:0]    ir_q, ir_d;
  logic [7:0]    a_d, b_d;
  logic [7:0]    result_q, result_d;
  logic          carry_q, carry_d;
  logic          rv_q, rv_d;
  logic          err_q, err_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [7:0]    rd_pc, rd_ea;

  assign rd_pc = mem[pc_q];
  assign rd_ea = mem[ea_q];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ld_ptr_d  = ld_ptr_q;
    ea_d      = ea_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    carry_d   = carry_q;
    rv_d      = 1'b0;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = ld_ptr_q;
    mem_wdata = ld_data;

    case (state_q)
      S_IDLE, S_HALTED: begin
        // Load and start may coincide; the write lands before the first fetch reads it.
        if (ld_valid) begin
          mem_we   = 1'b1;
          ld_ptr_d = ld_ptr_q + 1'b1;
        end
        if (start) begin
          pc_d    = start_addr;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = rd_pc[3:0];
        pc_d    = pc_q + 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_q)
          OP_NOP: ;
          OP_ADD: begin
            {carry_d, result_d} = {1'b0, a_q} + {1'b0, b_q};
            rv_d = 1'b1;
          end
          OP_SUB: begin
            result_d = a_q - b_q;
            carry_d  = (a_q < b_q);
            rv_d     = 1'b1;
          end
          OP_MOVA: begin
            a_d  = rd_pc;
            pc_d = pc_q + 1'b1;
          end
          OP_MOVB: begin
            b_d  = rd_pc;
            pc_d = pc_q + 1'b1;
          end
          OP_MOVAM, OP_MOVBM, OP_MOVM: begin
            ea_d    = rd_pc;
            pc_d    = pc_q + 1'b1;
            state_d = S_MEMOP;
          end
          OP_HALT: state_d = S_HALTED;
          default: begin
            err_d   = 1'b1;
            state_d = S_HALTED;
          end
        endcase
      end
      S_MEMOP: begin
        state_d = S_FETCH;
        case (ir_q)
          OP_MOVAM: a_d = rd_ea;
          OP_MOVBM: b_d = rd_ea;
          OP_MOVM: begin
            mem_we    = 1'b1;
            mem_waddr = ea_q;
            mem_wdata = result_q;
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ld_ptr_q <= '0;
      ea_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ld_ptr_q <= ld_ptr_d;
      ea_q     <= ea_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
    end
  end

  // Array is never reset; a reset edge also suppresses any pending write.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign busy         = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEMOP);
  assign halted       = (state_q == S_HALTED);
  assign err          = err_q;
  assign result       = result_q;
  assign carry        = carry_q;
  assign result_valid = rv_q;
  assign pc           = pc_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed scenarios plus random programs
// checked against an instruction-level reference model.
module tb_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst, ld_valid, start;
  logic [7:0] ld_data, start_addr;
  logic       busy, halted, err, carry, result_valid;
  logic [7:0] a_q, b_q, result, pc;

  exec_sequencer #(.DEPTH(256), .AW(8)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data),
    .start(start), .start_addr(start_addr), .busy(busy), .halted(halted),
    .err(err), .a_q(a_q), .b_q(b_q), .result(result), .carry(carry),
    .result_valid(result_valid), .pc(pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Shadow memory and architectural state of the reference model
  logic [7:0] m [256];
  logic [7:0] tb_ldp;
  logic [7:0] m_a, m_b, m_res;
  logic       m_c;
  // Model results
  logic [7:0] e_a, e_b, e_res, e_pc;
  logic       e_c, e_err, e_done;
  int         e_cyc, e_rv;
  // Observations captured right after the start edge
  logic       st_busy, st_err, st_halted;
  logic [7:0] a_hist [$];

  task automatic model_run(input logic [7:0] sa, input bit commit);
    logic [7:0] mm [256];
    logic [7:0] a, b, r, p, ea;
    logic [3:0] op;
    logic       c;
    int         cyc, rv, sum;
    mm = m; a = m_a; b = m_b; r = m_res; c = m_c;
    p = sa; cyc = 0; rv = 0; e_done = 1'b0; e_err = 1'b0;
    for (int n = 0; n < 400 && !e_done; n++) begin
      op = mm[p][3:0];
      p = p + 8'd1;
      case (op)
        4'h0: cyc += 2;
        4'h1: begin a = mm[p]; p = p + 8'd1; cyc += 2; end
        4'h2: begin b = mm[p]; p = p + 8'd1; cyc += 2; end
        4'h3: begin sum = int'(a) + int'(b); r = 8'(sum); c = (sum > 255); rv++; cyc += 2; end
        4'h6: begin r = a - b; c = (a < b); rv++; cyc += 2; end
        4'h8: begin cyc += 2; e_done = 1'b1; end
        4'h9: begin ea = mm[p]; p = p + 8'd1; a = mm[ea]; cyc += 3; end
        4'hA: begin ea = mm[p]; p = p + 8'd1; b = mm[ea]; cyc += 3; end
        4'hC: begin ea = mm[p]; p = p + 8'd1; mm[ea] = r; cyc += 3; end
        default: begin cyc += 2; e_err = 1'b1; e_done = 1'b1; end
      endcase
    end
    e_a = a; e_b = b; e_res = r; e_c = c; e_pc = p; e_cyc = cyc; e_rv = rv;
    if (commit) begin
      m = mm; m_a = a; m_b = b; m_res = r; m_c = c;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0; ld_valid = 1'b0; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_a = 8'h00; m_b = 8'h00; m_res = 8'h00; m_c = 1'b0; tb_ldp = 8'h00;
  endtask

  task automatic load_byte(input logic [7:0] d);
    ld_valid = 1'b1; ld_data = d;
    @(posedge clk);
    @(negedge clk);
    ld_valid = 1'b0;
    m[tb_ldp] = d;
    tb_ldp = tb_ldp + 8'd1;
  endtask

  // Start at sa and clock until halted (bounded); inj fires load/start pulses mid-run.
  task automatic run_dut(input logic [7:0] sa, input bit inj, output int edges, output int rvc);
    logic [7:0] a_prev;
    start = 1'b1; start_addr = sa;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    st_busy = busy; st_err = err; st_halted = halted;
    edges = 0; rvc = 0; a_prev = a_q; a_hist.delete();
    while (!halted && edges < 2000) begin
      if (inj && (edges == 2 || edges == 5)) begin
        ld_valid = 1'b1; ld_data = 8'hEE; start = 1'b1; start_addr = sa + 8'd1;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
      ld_valid = 1'b0; start = 1'b0;
      if (result_valid === 1'b1) rvc++;
      if (a_q !== a_prev) begin a_hist.push_back(a_q); a_prev = a_q; end
    end
  endtask

  task automatic test_reset();
    logic [7:0] ob [9];
    logic [7:0] b0;
    apply_reset();
    @(posedge clk);
    @(negedge clk);
    ob = '{pc, a_q, b_q, result, {7'd0, carry}, {7'd0, result_valid},
           {7'd0, busy}, {7'd0, halted}, {7'd0, err}};
    for (int i = 0; i < 9; i++) begin
      total++;
      if (ob[i] !== 8'h00) begin bad++; $display("FAIL reset_out%0d got=%h exp=00", i, ob[i]); end
    end
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      b0 = 8'($urandom);
      load_byte(b0);
    end
  endtask

  task automatic test_full_program();
    logic [7:0] prog [8];
    int edges, rvc;
    prog = '{8'h01, 8'h05, 8'h02, 8'h03, 8'h03, 8'h0C, 8'h10, 8'h08};
    for (int i = 0; i < 8; i++) load_byte(prog[i]);
    model_run(8'h00, 1'b1);
    run_dut(8'h00, 1'b0, edges, rvc);
    total++; if (st_busy !== 1'b1) begin bad++; $display("FAIL full_busy_rise got=%b exp=1", st_busy); end
    total++; if (edges != 11) begin bad++; $display("FAIL full_halt_edges got=%0d exp=11", edges); end
    total++; if (a_q !== 8'h05) begin bad++; $display("FAIL full_a got=%h exp=05", a_q); end
    total++; if (b_q !== 8'h03) begin bad++; $display("FAIL full_b got=%h exp=03", b_q); end
    total++; if (result !== 8'h08) begin bad++; $display("FAIL full_result got=%h exp=08", result); end
    total++; if (carry !== 1'b0) begin bad++; $display("FAIL full_carry got=%b exp=0", carry); end
    total++; if (rvc != 1) begin bad++; $display("FAIL full_rv_pulses got=%0d exp=1", rvc); end
    total++; if (pc !== 8'h08) begin bad++; $display("FAIL full_pc got=%h exp=08", pc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_fall got=%b exp=0", busy); end
    // Read back mem[0x10] through MOVAM to confirm the MOVM store
    load_byte(8'h09); load_byte(8'h10); load_byte(8'h08);
    model_run(8'h08, 1'b1);
    run_dut(8'h08, 1'b0, edges, rvc);
    total++; if (a_q !== 8'h08) begin bad++; $display("FAIL full_mem10 got=%h exp=08", a_q); end
    total++; if (edges != 5) begin bad++; $display("FAIL full_movam_edges got=%0d exp=5", edges); end
  endtask

  task automatic test_arith();
    logic [7:0] ta [3], tbv [3], top [3], tres [3];
    logic       tc [3];
    logic [7:0] sa;
    int edges, rvc;
    ta = '{8'hFF, 8'h03, 8'h05}; tbv = '{8'h02, 8'h05, 8'h05};
    top = '{8'h03, 8'h06, 8'h06}; tres = '{8'h01, 8'hFE, 8'h00}; tc = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      sa = tb_ldp;
      load_byte(8'h01); load_byte(ta[i]); load_byte(8'h02); load_byte(tbv[i]);
      load_byte(top[i]); load_byte(8'h08);
      model_run(sa, 1'b1);
      run_dut(sa, 1'b0, edges, rvc);
      total++; if (result !== tres[i]) begin bad++; $display("FAIL arith%0d_result got=%h exp=%h", i, result, tres[i]); end
      total++; if (carry !== tc[i]) begin bad++; $display("FAIL arith%0d_carry got=%b exp=%b", i, carry, tc[i]); end
      total++; if (rvc != 1) begin bad++; $display("FAIL arith%0d_rv got=%0d exp=1", i, rvc); end
      total++; if (edges != 8) begin bad++; $display("FAIL arith%0d_edges got=%0d exp=8", i, edges); end
    end
  endtask

  task automatic test_illegal();
    logic [7:0] sa;
    int edges, rvc;
    sa = tb_ldp;
    load_byte(8'h01); load_byte(8'h22); load_byte(8'h05); load_byte(8'h08);
    model_run(sa, 1'b1);
    run_dut(sa, 1'b0, edges, rvc);
    total++; if (edges != 4) begin bad++; $display("FAIL illegal_edges got=%0d exp=4", edges); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b exp=1", err); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL illegal_halted got=%b exp=1", halted); end
    total++; if (a_q !== 8'h22) begin bad++; $display("FAIL illegal_a got=%h exp=22", a_q); end
    total++; if (pc !== sa + 8'd3) begin bad++; $display("FAIL illegal_pc got=%h exp=%h", pc, sa + 8'd3); end
    total++; if (result !== 8'h00) begin bad++; $display("FAIL illegal_result_kept got=%h exp=00", result); end
  endtask

  task automatic test_ignored_busy();
    logic [7:0] sa;
    int edges, rvc;
    sa = tb_ldp;
    load_byte(8'h01); load_byte(8'h33); load_byte(8'h02); load_byte(8'h11);
    load_byte(8'h06); load_byte(8'h08);
    model_run(sa, 1'b1);
    run_dut(sa, 1'b1, edges, rvc);
    total++; if (st_err !== 1'b0) begin bad++; $display("FAIL busy_err_cleared got=%b exp=0", st_err); end
    total++; if (st_halted !== 1'b0) begin bad++; $display("FAIL busy_halt_cleared got=%b exp=0", st_halted); end
    total++; if (edges != 8) begin bad++; $display("FAIL busy_edges got=%0d exp=8", edges); end
    total++; if (result !== 8'h22) begin bad++; $display("FAIL busy_result got=%h exp=22", result); end
    total++; if (pc !== sa + 8'd6) begin bad++; $display("FAIL busy_pc got=%h exp=%h", pc, sa + 8'd6); end
    // ld_ptr must still point just past the program: a lone HALT lands there
    load_byte(8'h08);
    model_run(sa + 8'd6, 1'b1);
    run_dut(sa + 8'd6, 1'b0, edges, rvc);
    total++; if (edges != 2) begin bad++; $display("FAIL busy_ldptr_edges got=%0d exp=2", edges); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL busy_ldptr_err got=%b exp=0", err); end
  endtask

  task automatic test_wrap();
    logic [7:0] sa;
    int edges, rvc;
    while (tb_ldp != 8'hFF) load_byte(m[tb_ldp]);
    load_byte(8'h01); load_byte(8'h7A); load_byte(8'h09); load_byte(8'hFF); load_byte(8'h08);
    sa = 8'hFF;
    model_run(sa, 1'b1);
    run_dut(sa, 1'b0, edges, rvc);
    total++; if (a_hist.size() != 2) begin bad++; $display("FAIL wrap_a_changes got=%0d exp=2", a_hist.size()); end
    else begin
      total++; if (a_hist[0] !== 8'h7A) begin bad++; $display("FAIL wrap_a_first got=%h exp=7a", a_hist[0]); end
      total++; if (a_hist[1] !== 8'h01) begin bad++; $display("FAIL wrap_a_second got=%h exp=01", a_hist[1]); end
    end
    total++; if (pc !== 8'h04) begin bad++; $display("FAIL wrap_pc got=%h exp=04", pc); end
    total++; if (edges != 7) begin bad++; $display("FAIL wrap_edges got=%0d exp=7", edges); end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] prog [16];
    logic [7:0] ob [9];
    int edges, rvc;
    apply_reset();
    rst = 1'b1;
    prog = '{8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h0C, 8'h0F, 8'h09,
             8'h0F, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5C};
    for (int i = 0; i < 16; i++) load_byte(prog[i]);
    start = 1'b1; start_addr = 8'h00;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_in_memop got=%b exp=1", busy); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_a = 8'h00; m_b = 8'h00; m_res = 8'h00; m_c = 1'b0; tb_ldp = 8'h00;
    ob = '{pc, a_q, b_q, result, {7'd0, carry}, {7'd0, result_valid},
           {7'd0, busy}, {7'd0, halted}, {7'd0, err}};
    for (int i = 0; i < 9; i++) begin
      total++;
      if (ob[i] !== 8'h00) begin bad++; $display("FAIL midrst_out%0d got=%h exp=00", i, ob[i]); end
    end
    model_run(8'h07, 1'b1);
    run_dut(8'h07, 1'b0, edges, rvc);
    total++; if (a_q !== 8'h5C) begin bad++; $display("FAIL midrst_no_write got=%h exp=5c", a_q); end
    model_run(8'h00, 1'b1);
    run_dut(8'h00, 1'b0, edges, rvc);
    total++; if (a_q !== 8'h33) begin bad++; $display("FAIL midrst_rerun_a got=%h exp=33", a_q); end
    total++; if (edges != 14) begin bad++; $display("FAIL midrst_rerun_edges got=%0d exp=14", edges); end
    total++; if (pc !== 8'h0A) begin bad++; $display("FAIL midrst_rerun_pc got=%h exp=0a", pc); end
  endtask

  task automatic test_random();
    logic [3:0] legal [8];
    logic [3:0] illeg [7];
    logic [3:0] op;
    logic [7:0] sa, p;
    int k, edges, rvc;
    legal = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h9, 4'hA, 4'hC};
    illeg = '{4'h4, 4'h5, 4'h7, 4'hB, 4'hD, 4'hE, 4'hF};
    for (int t = 0; t < 12; t++) begin
      do begin
        for (int i = 0; i < 256; i++) m[i] = 8'($urandom);
        sa = 8'($urandom);
        p = sa;
        k = $urandom_range(3, 12);
        for (int j = 0; j < k; j++) begin
          op = legal[$urandom_range(0, 7)];
          m[p] = {4'($urandom), op};
          p = p + 8'd1;
          if (op == 4'h1 || op == 4'h2 || op == 4'h9 || op == 4'hA || op == 4'hC) begin
            m[p] = 8'($urandom);
            p = p + 8'd1;
          end
        end
        if ($urandom_range(0, 3) == 0) m[p] = {4'($urandom), illeg[$urandom_range(0, 6)]};
        else m[p] = {4'($urandom), 4'h8};
        model_run(sa, 1'b0);
      end while (!e_done || e_cyc > 1500);
      for (int i = 0; i < 256; i++) load_byte(m[tb_ldp]);
      model_run(sa, 1'b1);
      run_dut(sa, 1'b0, edges, rvc);
      total++; if (edges != e_cyc) begin bad++; $display("FAIL rnd%0d_edges got=%0d exp=%0d", t, edges, e_cyc); end
      total++; if (a_q !== e_a) begin bad++; $display("FAIL rnd%0d_a got=%h exp=%h", t, a_q, e_a); end
      total++; if (b_q !== e_b) begin bad++; $display("FAIL rnd%0d_b got=%h exp=%h", t, b_q, e_b); end
      total++; if (result !== e_res) begin bad++; $display("FAIL rnd%0d_result got=%h exp=%h", t, result, e_res); end
      total++; if (carry !== e_c) begin bad++; $display("FAIL rnd%0d_carry got=%b exp=%b", t, carry, e_c); end
      total++; if (pc !== e_pc) begin bad++; $display("FAIL rnd%0d_pc got=%h exp=%h", t, pc, e_pc); end
      total++; if (err !== e_err) begin bad++; $display("FAIL rnd%0d_err got=%b exp=%b", t, err, e_err); end
      total++; if (rvc != e_rv) begin bad++; $display("FAIL rnd%0d_rv got=%0d exp=%0d", t, rvc, e_rv); end
    end
  endtask

  initial begin
    rst = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; start = 1'b0; start_addr = 8'h00;
    @(negedge clk);
    test_reset();
    test_full_program();
    test_arith();
    test_illegal();
    test_ignored_busy();
    test_wrap();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
